// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: fetches sequential words from memory into a
// small FIFO, throttled by a credit check, with branch redirect and flush.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | no request outstanding
// S_REQ     | request outstanding, response will be pushed
// S_DISCARD | request outstanding, response dropped after a redirect
module instr_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         instr_valid,
    output logic [DATA_W-1:0]            instr_data,
    output logic [ADDR_W-1:0]            instr_pc,
    input  logic                         instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FL_W  = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FL_W-1:0]    fill_q, fill_d;

    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];

    logic               push, pop, credit, issue;
    logic [ADDR_W-1:0]  redirect_pc_al;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign redirect_pc_al = {redirect_pc[ADDR_W-1:2], 2'b00};

    assign instr_valid = (fill_q != '0);
    assign fill_level  = fill_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    // Head is gated to zero when empty so reset/flush show clean outputs.
    assign instr_data  = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : '0;

    // FIFO bookkeeping and fetch pc; redirect flushes and overrides push/pop.
    always_comb begin
        push       = (state_q == S_REQ) && mem_ack && !redirect_valid;
        pop        = instr_valid && instr_ready && !redirect_valid;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
            fetch_pc_d = redirect_pc_al;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            fill_d = fill_q + FL_W'(push) - FL_W'(pop);
        end
        // At most one request is ever outstanding, and a new one is only
        // considered once the previous one has completed this cycle.
        credit = (fill_d < FL_W'(DEPTH));
    end

    // Next-state and request issue logic.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        issue      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (credit && !redirect_valid) issue = 1'b1;
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (credit) issue = 1'b1;
                    else        state_d = S_IDLE;
                end else if (redirect_valid) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (mem_ack) begin
                    if (credit) issue = 1'b1;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            state_d    = S_REQ;
            mem_addr_d = fetch_pc_d;
        end
        mem_req_d = (state_d != S_IDLE);
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
        end
    end

    // FIFO storage; push cannot occur in reset because state is IDLE.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: doc/instr_prefetch_unit.md
INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32: width of all byte addresses.
REQ-002 Parameter DATA_W, default 32: instruction word width.
REQ-003 Parameter DEPTH, default 4: prefetch FIFO entries; power of two, minimum 2.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset; word-aligned.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 mem_req  output  1  fetch request to memory, registered.
REQ-008 mem_addr  output  ADDR_W  fetch byte address, registered; valid while mem_req is 1.
REQ-009 mem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-010 mem_rdata  input  DATA_W  fetched word; sampled only when mem_req and mem_ack are both 1.
REQ-011 redirect_valid  input  1  branch or jump: flush the FIFO and restart fetch.
REQ-012 redirect_pc  input  ADDR_W  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-013 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-014 instr_data  output  DATA_W  instruction word at the FIFO head.
REQ-015 instr_pc  output  ADDR_W  byte address of instr_data.
REQ-016 instr_ready  input  1  consumer pops the head when instr_valid is also 1.
REQ-017 fill_level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-018 FSM states: IDLE (no request), REQ (request outstanding), DISCARD (request outstanding; its response will be dropped).
REQ-019 mem_req = 1 in REQ and DISCARD. mem_addr SHALL stay constant from mem_req rise until the acknowledging cycle.
REQ-020 Credit rule: a new request is issued only when fill_level + outstanding < DEPTH, evaluated after this cycle's push and pop. The FIFO never overflows.
REQ-021 IDLE -> REQ on the next edge when the credit rule holds and redirect_valid = 0. mem_addr = fetch_pc.
REQ-022 REQ with mem_ack and no redirect:
  - push {fetch_pc, mem_rdata};
  - fetch_pc += 4, wrapping modulo 2^ADDR_W;
  - stay in REQ with the new address if the credit rule holds (back-to-back, mem_req stays 1), else go to IDLE.
REQ-023 Push-to-output latency: instr_valid is 1 on the edge after the acknowledging cycle (registered FIFO; no bypass).
REQ-024 Pop on instr_valid & instr_ready. A simultaneous push and pop leaves fill_level unchanged and preserves order.
REQ-025 instr_valid = (fill_level != 0). instr_data and instr_pc are stable while instr_valid = 1 and instr_ready = 0.
REQ-026 Redirect priority: redirect_valid has priority over push and pop in the same cycle. At the next edge:
  - FIFO empty (fill_level = 0, instr_valid = 0);
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  - any pop requested in that cycle is discarded.
REQ-027 Redirect while in REQ without mem_ack: go to DISCARD, keeping mem_req and the old mem_addr until mem_ack. The response is dropped, then the FSM goes to IDLE (or to REQ at the redirect address if credit allows).
REQ-028 Redirect in a cycle with mem_ack: the acked data is dropped, and the next request uses the redirect address.
REQ-029 Redirect while in DISCARD: update fetch_pc only; the state remains DISCARD.
REQ-030 FIFO pointers are log2(DEPTH) bits and wrap naturally.
REQ-031 Full FIFO with instr_ready held low: no requests are issued (IDLE) until a pop occurs.

Reset
REQ-032 While rst_n = 0, all of the following hold immediately (asynchronous):
  - state = IDLE; mem_req = 0; mem_addr = RESET_PC;
  - fetch_pc = RESET_PC; FIFO pointers = 0;
  - fill_level = 0; instr_valid = 0; instr_data = 0; instr_pc = 0.
REQ-033 After rst_n rises, mem_req = 1 with mem_addr = RESET_PC on the first rising edge of clk.
REQ-034 Reset asserted mid-request abandons the request. Any mem_ack received during reset is ignored.

Verification
REQ-035 Reset, then mem_ack tied to 1 and instr_ready tied to 1:
  - mem_addr sequence 0x0, 0x4, 0x8, ...;
  - instr_pc follows one cycle behind;
  - mem_req continuously 1.
REQ-036 DEPTH = 4, instr_ready = 0, mem_ack = 1: exactly 4 words are accepted, then mem_req = 0 and fill_level = 4. Raising instr_ready for one cycle -> one pop and one new request at 0x10.
REQ-037 Redirect to 0x103 while a request to 0x8 is pending with mem_ack low:
  - mem_req stays 1 at 0x8 until ack;
  - that data never appears on instr_data;
  - the next request goes to 0x100;
  - FIFO empty on the edge after the redirect.
REQ-038 Redirect, pop and mem_ack in the same cycle with fill_level = 2: next edge fill_level = 0, and the next fetch and instruction are at the redirect address.
REQ-039 fetch_pc = 2^ADDR_W - 4, ack -> next mem_addr = 0 and instr_pc of the pushed word = 2^ADDR_W - 4.
REQ-040 rst_n pulsed low asynchronously mid-request with fill_level = 3 -> all outputs at reset values before the next clk edge; fetch restarts at RESET_PC.
